// File: rtl/snd_bus_pkg.sv
// Shared definitions for the sound-chip bus scheduler: target codes,
// FSM states, write-queue entry width and the timer helper.
package snd_bus_pkg;

  localparam logic [1:0] TGT_YM1  = 2'd0;
  localparam logic [1:0] TGT_YM2  = 2'd1;
  localparam logic [1:0] TGT_SAA  = 2'd2;
  localparam logic [1:0] TGT_NONE = 2'd3;

  // Entry layout: {tgt[10:9], a0[8], d[7:0]}
  localparam int ENTRY_W = 11;
  localparam int REC_W   = 10;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

  // Timer reload value for a state lasting n cycles; 0 behaves as 1.
  function automatic logic [REC_W-1:0] ticks(input int n);
    return (n < 1) ? '0 : REC_W'(n - 1);
  endfunction

endpackage

// File: rtl/snd_wr_fifo.sv
// Small write queue for the sound bus scheduler; pushes while full are dropped
// even when a pop happens in the same cycle.
module snd_wr_fifo
  import snd_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ENTRY_W-1:0]       din,
  output logic [ENTRY_W-1:0]       dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/snd_bus_sched.sv
// Shared YM/YM/SAA bus scheduler: queued writes and level-held reads with
// setup/strobe/hold/recovery timing. Define SND_BUS_OVF_EN for the sticky ovf flag.
module snd_bus_sched
  import snd_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int T_SETUP    = 2,
  parameter int T_STROBE   = 4,
  parameter int T_HOLD     = 2,
  parameter int YM_AREC    = 160,
  parameter int YM_DREC    = 768,
  parameter int SAA_REC    = 8
) (
  input  logic       clk32,
  input  logic       rst_n,
  input  logic       req,
  input  logic [1:0] req_tgt,
  input  logic       req_a0,
  input  logic [7:0] req_d,
  output logic       req_rdy,
  input  logic       rd_req,
  input  logic       rd_tgt,
  input  logic       rd_a0,
  output logic       rd_ack,
  output logic [7:0] rd_d,
  output logic       bus_a0,
  output logic [7:0] bus_dout,
  output logic       bus_doe,
  input  logic [7:0] bus_din,
  output logic       n_bus_rd,
  output logic       n_bus_wr,
  output logic       n_cs_ym1,
  output logic       n_cs_ym2,
  output logic       n_cs_saa,
  output logic       busy,
  output logic       ovf
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t             state;
  logic [REC_W-1:0]   cnt;
  logic [REC_W-1:0]   rec_ticks;
  logic               is_rd;
  logic [1:0]         cur_tgt;
  logic               cur_a0;

  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [CW-1:0]      count;
  logic [ENTRY_W-1:0] head;
  logic [1:0]         head_tgt;
  logic               head_a0;
  logic [7:0]         head_d;

  assign req_rdy  = (count < CW'(FIFO_DEPTH)) && !rd_req;
  assign push     = req && req_rdy;
  assign pop      = (state == IDLE) && !empty;
  assign busy     = (state != IDLE) || !empty;
  assign head_tgt = head[10:9];
  assign head_a0  = head[8];
  assign head_d   = head[7:0];

  assign rec_ticks = (is_rd || cur_tgt == TGT_SAA) ? ticks(SAA_REC) :
                     (cur_a0 ? ticks(YM_DREC) : ticks(YM_AREC));

  snd_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk32),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({req_tgt, req_a0, req_d}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      is_rd    <= 1'b0;
      cur_tgt  <= TGT_NONE;
      cur_a0   <= 1'b0;
      n_cs_ym1 <= 1'b1;
      n_cs_ym2 <= 1'b1;
      n_cs_saa <= 1'b1;
      n_bus_rd <= 1'b1;
      n_bus_wr <= 1'b1;
      bus_doe  <= 1'b0;
      bus_dout <= '0;
      bus_a0   <= 1'b0;
      rd_ack   <= 1'b0;
      rd_d     <= '0;
    end else begin
      rd_ack <= 1'b0;
      case (state)
        IDLE: begin
          // Queued writes drain before any read is served.
          if (!empty) begin
            if (head_tgt != TGT_NONE) begin
              state    <= SETUP;
              cnt      <= ticks(T_SETUP);
              is_rd    <= 1'b0;
              cur_tgt  <= head_tgt;
              cur_a0   <= head_a0;
              n_cs_ym1 <= (head_tgt != TGT_YM1);
              n_cs_ym2 <= (head_tgt != TGT_YM2);
              n_cs_saa <= (head_tgt != TGT_SAA);
              bus_a0   <= head_a0;
              bus_dout <= head_d;
              bus_doe  <= 1'b1;
            end
          end else if (rd_req) begin
            state    <= SETUP;
            cnt      <= ticks(T_SETUP);
            is_rd    <= 1'b1;
            cur_tgt  <= rd_tgt ? TGT_YM2 : TGT_YM1;
            cur_a0   <= rd_a0;
            n_cs_ym1 <= rd_tgt;
            n_cs_ym2 <= !rd_tgt;
            n_cs_saa <= 1'b1;
            bus_a0   <= rd_a0;
            bus_doe  <= 1'b0;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state    <= STROBE;
            cnt      <= ticks(T_STROBE);
            n_bus_rd <= !is_rd;
            n_bus_wr <= is_rd;
          end else begin
            cnt <= cnt - REC_W'(1);
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            state    <= HOLD;
            cnt      <= ticks(T_HOLD);
            n_bus_rd <= 1'b1;
            n_bus_wr <= 1'b1;
            if (is_rd) begin
              rd_ack <= 1'b1;
              rd_d   <= bus_din;
            end
          end else begin
            cnt <= cnt - REC_W'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state    <= RECOVER;
            cnt      <= rec_ticks;
            n_cs_ym1 <= 1'b1;
            n_cs_ym2 <= 1'b1;
            n_cs_saa <= 1'b1;
            bus_doe  <= 1'b0;
          end else begin
            cnt <= cnt - REC_W'(1);
          end
        end
        RECOVER: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - REC_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SND_BUS_OVF_EN
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n)          ovf <= 1'b0;
    else if (req && full) ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_snd_bus_sched.sv
// Scoreboard bench for snd_bus_sched: stimulus queues expected bus accesses,
// a negedge monitor checks each access and its timing as it appears on the bus.
module tb_snd_bus_sched;
  import snd_bus_pkg::*;

  logic       clk32 = 1'b0;
  logic       rst_n;
  logic       req;
  logic [1:0] req_tgt;
  logic       req_a0;
  logic [7:0] req_d;
  logic       req_rdy;
  logic       rd_req;
  logic       rd_tgt;
  logic       rd_a0;
  logic       rd_ack;
  logic [7:0] rd_d;
  logic       bus_a0;
  logic [7:0] bus_dout;
  logic       bus_doe;
  logic [7:0] bus_din;
  logic       n_bus_rd;
  logic       n_bus_wr;
  logic       n_cs_ym1;
  logic       n_cs_ym2;
  logic       n_cs_saa;
  logic       busy;
  logic       ovf;

  snd_bus_sched dut (
    .clk32(clk32), .rst_n(rst_n),
    .req(req), .req_tgt(req_tgt), .req_a0(req_a0), .req_d(req_d), .req_rdy(req_rdy),
    .rd_req(rd_req), .rd_tgt(rd_tgt), .rd_a0(rd_a0), .rd_ack(rd_ack), .rd_d(rd_d),
    .bus_a0(bus_a0), .bus_dout(bus_dout), .bus_doe(bus_doe), .bus_din(bus_din),
    .n_bus_rd(n_bus_rd), .n_bus_wr(n_bus_wr),
    .n_cs_ym1(n_cs_ym1), .n_cs_ym2(n_cs_ym2), .n_cs_saa(n_cs_saa),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk32 = ~clk32;

  // Expected access: cs is {ym1,ym2,saa} active-high; rec is the RECOVER length.
  typedef struct {
    logic [2:0] cs;
    logic       rd;
    logic       a0;
    logic [7:0] d;
    int         rec;
    logic       abort;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cs_falls = 0;
  int   cs_rises = 0;
  int   st_falls = 0;
  int   last_cs = 0;
  int   last_st = 0;

`ifdef SND_BUS_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  always @(posedge clk32) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk32);
    #1;
  endtask

  task automatic exp_acc(input logic [2:0] cs, input logic rd, input logic a0,
                         input logic [7:0] d, input int rec, input logic abort);
    exp_t e;
    e.cs = cs; e.rd = rd; e.a0 = a0; e.d = d; e.rec = rec; e.abort = abort;
    expq.push_back(e);
  endtask

  task automatic drive_wr(input logic [1:0] tgt, input logic a0, input logic [7:0] d);
    req = 1'b1; req_tgt = tgt; req_a0 = a0; req_d = d;
    tick();
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin tick(); n++; end
    if (busy) check(name, 32'(busy), 0);
  endtask

  // Monitor: follows each chip-select window and compares it to the queue head.
  initial begin
    logic [2:0] cs, prev_cs;
    logic st_lo, prev_st, prev_busy, in_txn, rec_pending;
    int t_cs, t_st, t_sr, t_rec, rec_len;
    exp_t e;
    prev_cs = 0; prev_st = 0; prev_busy = 0; in_txn = 0; rec_pending = 0;
    t_cs = 0; t_st = 0; t_sr = 0; t_rec = 0; rec_len = 0;
    forever begin
      @(negedge clk32);
      cs    = ~{n_cs_ym1, n_cs_ym2, n_cs_saa};
      st_lo = !n_bus_wr || !n_bus_rd;
      if (!rst_n) begin
        if (in_txn) begin
          if (expq.size() == 0) check("abort_queue", 0, 1);
          else begin e = expq.pop_front(); check("abort_flag", 32'(e.abort), 1); end
        end
        in_txn = 0;
        rec_pending = 0;
      end else begin
        if (prev_cs == 0 && cs != 0) begin
          cs_falls++; t_cs = cyc; last_cs = cyc; in_txn = 1;
          if (rec_pending) begin
            // RECOVER length plus the IDLE cycle that pops the next entry
            check("recover_gap", 32'(cyc - t_rec), 32'(rec_len + 1));
            rec_pending = 0;
          end
          if (expq.size() == 0) check("unexpected_cs", 32'(cs), 0);
          else begin
            check("cs_sel", 32'(cs), 32'(expq[0].cs));
            check("cs_onehot", 32'($onehot(cs)), 1);
          end
        end
        if (!prev_st && st_lo) begin
          st_falls++; t_st = cyc; last_st = cyc;
          check("strobe_excl", 32'(!n_bus_wr && !n_bus_rd), 0);
          check("setup_len", 32'(cyc - t_cs), 32'(2));
          if (expq.size() != 0) begin
            e = expq[0];
            check("strobe_kind", 32'(!n_bus_rd), 32'(e.rd));
            check("bus_a0", 32'(bus_a0), 32'(e.a0));
            check("cs_held", 32'(cs), 32'(e.cs));
            if (!e.rd) check("wr_data", {23'd0, bus_doe, bus_dout}, {23'd0, 1'b1, e.d});
            else       check("rd_doe", 32'(bus_doe), 0);
          end
        end
        if (prev_st && !st_lo) begin
          t_sr = cyc;
          check("strobe_len", 32'(cyc - t_st), 32'(4));
          if (expq.size() != 0 && expq[0].rd) begin
            check("rd_ack", 32'(rd_ack), 1);
            check("rd_d", 32'(rd_d), 32'(expq[0].d));
          end
        end
        if (prev_cs != 0 && cs == 0) begin
          cs_rises++; in_txn = 0;
          check("hold_len", 32'(cyc - t_sr), 32'(2));
          check("doe_off", 32'(bus_doe), 0);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            rec_pending = 1; t_rec = cyc; rec_len = e.rec;
          end
        end
        if (rec_pending && prev_busy && !busy) begin
          check("recover_len", 32'(cyc - t_rec), 32'(rec_len));
          rec_pending = 0;
        end
      end
      prev_cs = cs; prev_st = st_lo; prev_busy = busy;
    end
  end

  initial begin
    int t_push, n0, n;
    rst_n = 1'b0; req = 1'b0; req_tgt = 2'd0; req_a0 = 1'b0; req_d = 8'h00;
    rd_req = 1'b0; rd_tgt = 1'b0; rd_a0 = 1'b0; bus_din = 8'h5A;
    repeat (3) tick();

    // Reset values
    check("rst_strobes_sel", {27'd0, n_cs_ym1, n_cs_ym2, n_cs_saa, n_bus_rd, n_bus_wr}, 32'h1F);
    check("rst_flags", {28'd0, bus_doe, rd_ack, busy, ovf}, 0);
    check("rst_data", {15'd0, bus_dout, rd_d, bus_a0}, 0);
    check("rst_req_rdy", 32'(req_rdy), 1);
    rst_n = 1'b1;
    repeat (2) tick();

    // YM1 a0=0 d=07 from idle
    exp_acc(3'b100, 1'b0, 1'b0, 8'h07, 160, 1'b0);
    n0 = cs_falls;
    drive_wr(TGT_YM1, 1'b0, 8'h07);
    t_push = cyc;
    req = 1'b0;
    n = 0;
    while (st_falls == 0 && n < 20) begin tick(); n++; end
    check("ym1_cs_seen", 32'(cs_falls - n0), 1);
    check("ym1_cs_latency", 32'(last_cs - t_push), 1);
    check("ym1_strobe_latency", 32'(last_st - t_push), 3);
    n = 0;
    while (cs_rises == 0 && n < 20) begin tick(); n++; end
    check("ym1_done", 32'(cs_rises), 1);

    // Five back-to-back pushes during YM1 recovery: the fifth is dropped
    exp_acc(3'b010, 1'b0, 1'b0, 8'h11, 160, 1'b0);
    exp_acc(3'b001, 1'b0, 1'b1, 8'h22, 8,   1'b0);
    exp_acc(3'b100, 1'b0, 1'b1, 8'h33, 768, 1'b0);
    exp_acc(3'b010, 1'b0, 1'b1, 8'h44, 768, 1'b0);
    n0 = cs_falls;
    drive_wr(TGT_YM2, 1'b0, 8'h11);
    drive_wr(TGT_SAA, 1'b1, 8'h22);
    drive_wr(TGT_YM1, 1'b1, 8'h33);
    drive_wr(TGT_YM2, 1'b1, 8'h44);
    check("full_req_rdy", 32'(req_rdy), 0);
    drive_wr(TGT_YM1, 1'b0, 8'h55);
    req = 1'b0;
    check("ovf_after_drop", 32'(ovf), 32'(OVF_EXP));
    wait_idle("ovf_idle_timeout", 5000);
    check("ovf_bus_writes", 32'(cs_falls - n0), 4);
    check("ovf_queue_empty", 32'(expq.size()), 0);

    // Two writes then a YM2 read; the read must wait behind both writes
    exp_acc(3'b001, 1'b0, 1'b0, 8'hA1, 8, 1'b0);
    exp_acc(3'b001, 1'b0, 1'b1, 8'hA2, 8, 1'b0);
    exp_acc(3'b010, 1'b1, 1'b0, 8'h5A, 8, 1'b0);
    drive_wr(TGT_SAA, 1'b0, 8'hA1);
    drive_wr(TGT_SAA, 1'b1, 8'hA2);
    req = 1'b0;
    rd_req = 1'b1; rd_tgt = 1'b1; rd_a0 = 1'b0;
    #1;
    check("rd_req_rdy", 32'(req_rdy), 0);
    n = 0;
    while (!rd_ack && n < 200) begin tick(); n++; end
    check("rd_ack_seen", 32'(rd_ack), 1);
    check("rd_ack_data", 32'(rd_d), 32'h5A);
    rd_req = 1'b0;
    wait_idle("rd_idle_timeout", 200);
    check("rd_queue_empty", 32'(expq.size()), 0);

    // Discarded tgt=3 entry followed by an SAA write
    exp_acc(3'b001, 1'b0, 1'b1, 8'h1C, 8, 1'b0);
    n0 = cs_falls;
    drive_wr(TGT_NONE, 1'b0, 8'hFF);
    drive_wr(TGT_SAA, 1'b1, 8'h1C);
    req = 1'b0;
    wait_idle("saa_idle_timeout", 200);
    check("none_no_bus", 32'(cs_falls - n0), 1);

    // Reset asserted in the middle of a YM1 strobe
    check("ovf_sticky", 32'(ovf), 32'(OVF_EXP));
    exp_acc(3'b100, 1'b0, 1'b0, 8'h99, 160, 1'b1);
    n0 = st_falls;
    drive_wr(TGT_YM1, 1'b0, 8'h99);
    req = 1'b0;
    n = 0;
    while (st_falls == n0 && n < 20) begin tick(); n++; end
    check("abort_strobe_seen", 32'(st_falls - n0), 1);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_release", {29'd0, n_bus_wr, n_cs_ym1, bus_doe}, 32'b110);
    tick();
    rst_n = 1'b1;
    n0 = cs_falls;
    repeat (10) tick();
    check("abort_busy", 32'(busy), 0);
    check("abort_req_rdy", 32'(req_rdy), 1);
    check("abort_ovf_clear", 32'(ovf), 0);
    check("abort_no_bus", 32'(cs_falls - n0), 0);
    check("final_queue_empty", 32'(expq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snd_bus_sched.md
SND_BUS_SCHED -- requirements
Module: snd_bus_sched

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, named as the codebase does: clk32 and rst_n.
REQ-002 Parameters (name, default, meaning) SHALL be:
- FIFO_DEPTH, 4: write queue entries, power of 2.
- T_SETUP, 2: clk32 cycles from chip select and address/data to the strobe.
- T_STROBE, 4: strobe-low cycles.
- T_HOLD, 2: cycles after the strobe with chip select still held.
- YM_AREC, 160: recovery after a YM write with a0=0.
- YM_DREC, 768: recovery after a YM write with a0=1.
- SAA_REC, 8: recovery after any SAA access and after any read.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk32, in, 1, clock.
- rst_n, in, 1, async reset.
- req, in, 1, write request, valid for one cycle.
- req_tgt, in, 2, target: 0=YM1, 1=YM2, 2=SAA, 3=none.
- req_a0, in, 1, chip register select.
- req_d, in, 8, write data.
- req_rdy, out, 1, write accepted when high.
- rd_req, in, 1, read request; level, held until acknowledged.
- rd_tgt, in, 1, 0=YM1, 1=YM2.
- rd_a0, in, 1, chip register select for the read.
- rd_ack, out, 1, one-cycle pulse.
- rd_d, out, 8, read data, valid while rd_ack is high.
- bus_a0, out, 1, chip address line.
- bus_dout, out, 8, data driven to the chips.
- bus_doe, out, 1, data output enable.
- bus_din, in, 8, data from the chips.
- n_bus_rd, out, 1, read strobe.
- n_bus_wr, out, 1, write strobe.
- n_cs_ym1, out, 1, YM1 chip select.
- n_cs_ym2, out, 1, YM2 chip select.
- n_cs_saa, out, 1, SAA chip select.
- busy, out, 1, high when the FSM is not IDLE or the FIFO is not empty.
- ovf, out, 1, sticky overflow flag (see Configuration).

Function
REQ-004 A write SHALL be pushed into the FIFO as entry {tgt,a0,d} when req=1 and req_rdy=1.
REQ-005 req_rdy SHALL equal (registered count < FIFO_DEPTH) AND NOT rd_req.
- A push while the FIFO is full SHALL be dropped, even if a pop occurs in the same cycle.
REQ-006 The FSM states SHALL be IDLE, SETUP, STROBE, HOLD and RECOVER.
- Each timed state SHALL last exactly its parameter count; a count of 0 SHALL be treated as 1.
REQ-007 In IDLE, a pending read (rd_req=1) SHALL be served only when the FIFO is empty.
- Otherwise a non-empty FIFO SHALL be popped, and the FSM SHALL enter SETUP on the next cycle.
REQ-008 SETUP SHALL assert the selected n_cs_*, drive bus_a0, and, for writes only, drive bus_dout with bus_doe=1.
REQ-009 STROBE SHALL assert n_bus_wr for writes or n_bus_rd for reads; all outputs asserted in SETUP SHALL be held.
REQ-010 HOLD SHALL deassert the strobe and keep chip select, a0 and data stable.
REQ-011 RECOVER SHALL deassert all selects and bus_doe.
- The RECOVER length SHALL be YM_AREC (YM write, a0=0), YM_DREC (YM write, a0=1) or SAA_REC (SAA access or any read).
- The FSM SHALL then return to IDLE.
REQ-012 A read SHALL sample bus_din on the last STROBE cycle.
- rd_ack SHALL pulse high for the first HOLD cycle with rd_d equal to the sampled value.
REQ-013 An entry with tgt=3 SHALL be popped and discarded with no select, no strobe and no RECOVER; the FSM SHALL stay in IDLE.
REQ-014 The entry-to-strobe latency from an IDLE, empty, recovered state SHALL be 1 + T_SETUP cycles after the push.
REQ-015 At most one chip select SHALL be low at any time.
- n_bus_rd and n_bus_wr SHALL never be low together.
REQ-016 The recovery counter SHALL be 10 bits, and all recovery parameters SHALL be at most 1023.

Reset
REQ-017 While rst_n=0, all outputs SHALL be held asynchronously at their reset values:
- n_cs_*, n_bus_rd, n_bus_wr = 1.
- bus_doe, rd_ack, busy, ovf = 0.
- bus_dout, rd_d, bus_a0 = 0.
- req_rdy = 1 (when rd_req=0).
- FIFO empty; FSM in IDLE.
REQ-018 A reset during STROBE SHALL abort the access, release the strobe immediately and skip recovery.

Configuration
REQ-019 With SND_BUS_OVF_EN defined, ovf SHALL set on any dropped push and clear only on reset.
REQ-020 Without SND_BUS_OVF_EN, ovf SHALL be constant 0 and the overflow logic SHALL be absent.

Structure
REQ-021 Package snd_bus_pkg SHALL hold:
- the target encoding constants;
- the FSM state enum;
- the FIFO entry width (11 bits).
REQ-022 The FIFO SHALL be a sub-module snd_wr_fifo with push, pop, full, empty and count; the FSM and timers SHALL stay in snd_bus_sched.

Verification
REQ-023 Write YM1 a0=0 d=0x07 from idle:
- n_cs_ym1 falls 1 cycle after the push;
- n_bus_wr is low for 4 cycles starting at cycle 3;
- the next access starts 160 cycles after HOLD ends.
REQ-024 Push 5 back-to-back writes with FIFO_DEPTH=4:
- the 5th push is dropped;
- ovf=1 (with the macro), ovf=0 (without);
- exactly 4 bus writes occur, in push order.
REQ-025 Queue 2 writes, then raise rd_req with rd_tgt=1 while bus_din=0x5A:
- req_rdy drops immediately;
- the read follows both writes;
- rd_ack pulses with rd_d=0x5A; n_cs_ym2 and n_bus_rd are low.
REQ-026 Push tgt=3 followed by an SAA write d=0x1C a0=1:
- there is no bus activity for the tgt=3 entry;
- the SAA write strobe starts after T_SETUP, with bus_a0=1;
- recovery lasts 8 cycles.
REQ-027 Pulse rst_n low mid-STROBE:
- n_bus_wr and the selects go high in the same cycle;
- the FIFO is empty and busy=0 after release.
